// File: rtl/dds_mixer.sv
// Multi-channel DDS tone mixer: walks each channel's phase accumulator through a
// shared waveform ROM, scales by per-channel gain, sums and saturates per tick.
module dds_mixer #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 10,
    parameter int NCH     = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic [NCH-1:0]           ch_en,
    input  logic [NCH*PHASE_W-1:0]   phase_inc,
    input  logic [NCH*8-1:0]         gain,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_q,
    output logic [DATA_W-1:0]        sample_out,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam int ACC_W = DATA_W + $clog2(NCH) + 1;
    localparam int PW    = DATA_W + 10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MAC  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic signed [ACC_W:0] HALF_Y = (ACC_W+1)'(2**(DATA_W-1));
    localparam logic signed [ACC_W:0] MAX_Y  = (ACC_W+1)'(2**DATA_W - 1);
    localparam logic [DATA_W-1:0]     SILENCE = DATA_W'(2**(DATA_W-1));

    logic [2:0]               state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [PHASE_W-1:0]       phase_q [NCH];
    logic [PHASE_W-1:0]       phase_d [NCH];
    logic [7:0]               gain_q, gain_d;
    logic                     en_q, en_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]        sample_q, sample_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic signed [DATA_W:0]   s;
    logic signed [PW-1:0]     s_x, g_x, prod;
    logic signed [ACC_W-1:0]  p;
    logic signed [ACC_W:0]    y;
    logic [DATA_W-1:0]        y_sat;

    // Offset binary to two's complement is an MSB flip, then sign-extend one bit.
    always_comb begin
        s     = {~rom_q[DATA_W-1], ~rom_q[DATA_W-1], rom_q[DATA_W-2:0]};
        s_x   = {{(PW-DATA_W-1){s[DATA_W]}}, s};
        g_x   = {{(PW-8){1'b0}}, gain_q};
        prod  = s_x * g_x;
        p     = ACC_W'(prod >>> 8);
        y     = {acc_q[ACC_W-1], acc_q} + HALF_Y;
        if (y[ACC_W])
            y_sat = '0;
        else if (y > MAX_Y)
            y_sat = '1;
        else
            y_sat = y[DATA_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        gain_d     = gain_q;
        en_d       = en_q;
        rom_addr_d = rom_addr_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        overrun_d  = overrun_q | (tick & busy_q);
        for (int unsigned i = 0; i < NCH; i++)
            phase_d[i] = phase_q[i];

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_ADDR;
                    k_d     = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ADDR: begin
                rom_addr_d = phase_q[k_q][PHASE_W-1 -: ADDR_W];
                if (ch_en[k_q])
                    phase_d[k_q] = phase_q[k_q] + phase_inc[int'(k_q)*PHASE_W +: PHASE_W];
                gain_d  = gain[int'(k_q)*8 +: 8];
                en_d    = ch_en[k_q];
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CW'(ROM_LAT-1))
                    state_d = S_MAC;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            S_MAC: begin
                if (en_q)
                    acc_d = acc_q + p;
                if (k_q == KW'(NCH-1)) begin
                    state_d = S_OUT;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_ADDR;
                end
            end
            S_OUT: begin
                sample_d = y_sat;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            gain_q     <= '0;
            en_q       <= 1'b0;
            rom_addr_q <= '0;
            sample_q   <= SILENCE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++)
                phase_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            gain_q     <= gain_d;
            en_q       <= en_d;
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            for (int unsigned i = 0; i < NCH; i++)
                phase_q[i] <= phase_d[i];
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dds_mixer.sv
// Self-checking bench for dds_mixer at default parameters: vector table, frame
// timing checks, overrun and mid-frame reset sequences, sample scoreboard.
module tb_dds_mixer;

    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 10;
    localparam int NCH     = 2;
    localparam int ROM_LAT = 1;
    localparam int F       = NCH*(ROM_LAT+2)+1;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   tick = 1'b0;
    logic [NCH-1:0]         ch_en = '0;
    logic [NCH*PHASE_W-1:0] phase_inc = '0;
    logic [NCH*8-1:0]       gain = '0;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_q = '0;
    logic [DATA_W-1:0]      sample_out;
    logic                   sample_valid;
    logic                   busy;
    logic                   overrun;

    dds_mixer #(
        .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .NCH(NCH), .ROM_LAT(ROM_LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick), .ch_en(ch_en),
        .phase_inc(phase_inc), .gain(gain), .rom_addr(rom_addr), .rom_q(rom_q),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .overrun(overrun)
    );

    always #10 clock = ~clock;

    // One-cycle-latency ROM: identity (q = addr) or a constant.
    logic            rom_mode = 1'b0;
    logic [9:0]      rom_const = '0;
    always @(posedge clock) rom_q <= rom_mode ? rom_const : rom_addr;

    int vecs = 0;
    int errs = 0;
    int valid_cnt = 0;
    logic [9:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && sample_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0)
                check("unexpected sample_valid", 1, 0);
            else
                check("sample_out", int'(sample_out), int'(exp_q.pop_front()));
        end
    end

    // Reference model
    logic [15:0] mph  [2];
    logic [15:0] minc [2];
    logic [7:0]  mg   [2];
    logic [1:0]  men;

    task automatic model_frame(output logic [9:0] a0, output logic [9:0] a1,
                               output logic [9:0] yo);
        int acc, q, sv, pv, yv;
        logic [9:0] a;
        acc = 0;
        a0 = '0;
        a1 = '0;
        for (int k = 0; k < 2; k++) begin
            a = mph[k][15:6];
            if (k == 0) a0 = a; else a1 = a;
            q  = rom_mode ? int'(rom_const) : int'(a);
            sv = q - 512;
            pv = (sv * int'(mg[k])) >>> 8;
            if (men[k]) begin
                acc += pv;
                mph[k] = mph[k] + minc[k];
            end
        end
        yv = acc + 512;
        if (yv < 0) yv = 0;
        if (yv > 1023) yv = 1023;
        yo = yv[9:0];
    endtask

    task automatic set_inputs(input logic [1:0] en, input logic [15:0] i0,
                              input logic [15:0] i1, input logic [7:0] g0,
                              input logic [7:0] g1, input logic md,
                              input logic [9:0] cst);
        ch_en = en; phase_inc = {i1, i0}; gain = {g1, g0};
        rom_mode = md; rom_const = cst;
        men = en; minc[0] = i0; minc[1] = i1; mg[0] = g0; mg[1] = g1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rom_addr"}, int'(rom_addr), 0);
        check({tag, " sample_out"}, int'(sample_out), 512);
        check({tag, " sample_valid"}, int'(sample_valid), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " overrun"}, int'(overrun), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        tick = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mph[0] = '0;
        mph[1] = '0;
        exp_q.delete();
    endtask

    task automatic run_frame(input bit use_first, input logic [9:0] first_y);
        logic [9:0] a0, a1, y;
        model_frame(a0, a1, y);
        @(negedge clock);
        exp_q.push_back(use_first ? first_y : y);
        tick = 1'b1;
        @(negedge clock);               // after edge 0
        tick = 1'b0;
        @(negedge clock);               // after edge 1
        check("rom_addr ch0", int'(rom_addr), int'(a0));
        check("busy edge1", int'(busy), 1);
        repeat (3) @(negedge clock);    // after edge 4
        check("rom_addr ch1", int'(rom_addr), int'(a1));
        repeat (2) @(negedge clock);    // after edge F-1
        check("valid early", int'(sample_valid), 0);
        check("busy edge F-1", int'(busy), 1);
        @(negedge clock);               // after edge F
        check("valid at F", int'(sample_valid), 1);
        check("busy at F", int'(busy), 0);
        @(negedge clock);
        check("valid one cycle", int'(sample_valid), 0);
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [15:0] i0, i1;
        logic [7:0]  g0, g1;
        logic        md;
        logic [9:0]  cst;
        int          nfr;
        logic [9:0]  y0;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b01, 16'd64,    16'd0,      8'd255, 8'd0,   1'b0, 10'd0,    2, 10'd2};
        tbl[1] = '{2'b01, 16'd64,    16'd0,      8'd0,   8'd0,   1'b0, 10'd0,    2, 10'd512};
        tbl[2] = '{2'b00, 16'd64,    16'd64,     8'd255, 8'd255, 1'b0, 10'd0,    3, 10'd512};
        tbl[3] = '{2'b11, 16'd64,    16'd64,     8'd255, 8'd255, 1'b1, 10'd1023, 2, 10'd1023};
        tbl[4] = '{2'b11, 16'd64,    16'd64,     8'd255, 8'd255, 1'b1, 10'd0,    2, 10'd0};
        tbl[5] = '{2'b01, 16'hFFC0,  16'd0,      8'd255, 8'd0,   1'b0, 10'd0,    3, 10'd2};
        tbl[6] = '{2'b11, 16'd64,    16'h1000,   8'd128, 8'd200, 1'b0, 10'd0,    3, 10'd0};
        tbl[7] = '{2'b10, 16'd0,     16'h0400,   8'd0,   8'd255, 1'b0, 10'd0,    3, 10'd2};

        for (int v = 0; v < 8; v++) begin
            set_inputs(tbl[v].en, tbl[v].i0, tbl[v].i1, tbl[v].g0, tbl[v].g1,
                       tbl[v].md, tbl[v].cst);
            do_reset();
            check_reset_state("reset");
            for (int f = 0; f < tbl[v].nfr; f++) begin
                run_frame(f == 0, tbl[v].y0);
                repeat (12) @(negedge clock);
            end
        end

        // Ticks every 3 cycles: only ticks arriving while idle start a frame.
        begin
            int next_ok, accepted, cnt0;
            bit ign;
            logic [9:0] a0, a1, y;
            set_inputs(2'b01, 16'd64, 16'd0, 8'd255, 8'd0, 1'b0, 10'd0);
            do_reset();
            next_ok = 0; accepted = 0; ign = 0; cnt0 = valid_cnt;
            for (int c = 0; c <= 40; c++) begin
                tick = (c % 3 == 0) && (c < 30);
                if (tick) begin
                    if (c >= next_ok) begin
                        model_frame(a0, a1, y);
                        exp_q.push_back(y);
                        accepted++;
                        next_ok = c + F + 1;
                    end else begin
                        ign = 1;
                    end
                end
                @(negedge clock);
                check("overrun", int'(overrun), int'(ign));
            end
            tick = 1'b0;
            check("valid count under overrun", valid_cnt - cnt0, accepted);
        end

        // Reset in the middle of a frame with non-trivial state pending.
        begin
            int cnt0;
            @(negedge clock);
            tick = 1'b1;
            @(negedge clock);           // after edge 0
            tick = 1'b0;
            @(negedge clock);           // after edge 1
            check("pre-reset overrun", int'(overrun), 1);
            @(negedge clock);           // after edge 2
            reset_n = 1'b0;
            @(negedge clock);           // after edge 3
            exp_q.delete();
            check_reset_state("mid-frame reset");
            reset_n = 1'b1;
            cnt0 = valid_cnt;
            for (int c = 0; c < 12; c++) begin
                @(negedge clock);
                check("no valid after reset", int'(sample_valid), 0);
            end
            check("valid count after reset", valid_cnt - cnt0, 0);
            check("overrun stays clear", int'(overrun), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
